dispatch_ctrl: RTL

//  Issue-stage sequencer between the fetcher and the out-of-order back end. It buffers

---
 rtl/dispatch_ctrl_pkg.sv | 51 +++++
 rtl/dispatch_ctrl_iq.sv | 47 ++++
 rtl/dispatch_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/dispatch_ctrl_pkg.sv
// dispatch_ctrl_pkg: shared widths, op enums (LB..SW contiguous), IQ entry and dispatch payload types
package dispatch_ctrl_pkg;
  localparam int INS_LEN = 32;
  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;
  localparam int REG_LEN = 5;
  localparam int OPENUM_LEN = 6;
  localparam int DEF_IQ_DEPTH = 8;
  localparam int DEF_IQ_AW = 3;
  localparam int DEF_ROB_ID_LEN = 4;
  localparam logic [OPENUM_LEN-1:0] OPENUM_NOP = 6'd0;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LUI = 6'd1;
  localparam logic [OPENUM_LEN-1:0] OPENUM_AUIPC = 6'd2;
  localparam logic [OPENUM_LEN-1:0] OPENUM_JAL = 6'd3;
  localparam logic [OPENUM_LEN-1:0] OPENUM_JALR = 6'd4;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BEQ = 6'd5;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BNE = 6'd6;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BLT = 6'd7;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BGE = 6'd8;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BLTU = 6'd9;
  localparam logic [OPENUM_LEN-1:0] OPENUM_BGEU = 6'd10;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LB = 6'd11;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LH = 6'd12;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LW = 6'd13;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LBU = 6'd14;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LHU = 6'd15;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SB = 6'd16;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SH = 6'd17;
  localparam logic [OPENUM_LEN-1:0] OPENUM_SW = 6'd18;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ADDI = 6'd19;
  localparam logic [OPENUM_LEN-1:0] OPENUM_ADD = 6'd28;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LS_LO = OPENUM_LB;
  localparam logic [OPENUM_LEN-1:0] OPENUM_LS_HI = OPENUM_SW;
  typedef struct packed {
    logic [INS_LEN-1:0]  inst;
    logic [ADDR_LEN-1:0] pc;
    logic                pred_jump;
  } iq_entry_t;
  typedef struct packed {
    logic [OPENUM_LEN-1:0] op_enum;
    logic [REG_LEN-1:0]    rd;
    logic [REG_LEN-1:0]    rs1;
    logic [REG_LEN-1:0]    rs2;
    logic [DATA_LEN-1:0]   imm;
    logic [ADDR_LEN-1:0]   pc;
    logic                  pred_jump;
  } disp_payload_t;
  function automatic logic is_ls_op(input logic [OPENUM_LEN-1:0] op);
    return op >= OPENUM_LS_LO && op <= OPENUM_LS_HI;
  endfunction
endpackage

// File: rtl/dispatch_ctrl_iq.sv
// inst_queue: circular instruction buffer; clk/rst/rdy/flush/enq/deq/wr_entry in, head_entry/empty/iq_full/count out
module inst_queue
  import dispatch_ctrl_pkg::*;
#(
  parameter int IQ_DEPTH = DEF_IQ_DEPTH,
  parameter int IQ_AW = DEF_IQ_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            enq,
  input  logic            deq,
  input  iq_entry_t       wr_entry,
  output iq_entry_t       head_entry,
  output logic            empty,
  output logic            iq_full,
  output logic [IQ_AW:0]  count
);
  localparam logic [IQ_AW:0] CAP = (IQ_AW+1)'(IQ_DEPTH);
  localparam logic [IQ_AW:0] CAP_M1 = (IQ_AW+1)'(IQ_DEPTH - 1);
  iq_entry_t mem [IQ_DEPTH];
  logic [IQ_AW-1:0] head, tail;
  logic enq_ok;
  logic [IQ_AW:0] count_nx;
  assign enq_ok = enq && count != CAP;
  assign count_nx = count + (IQ_AW+1)'(enq_ok) - (IQ_AW+1)'(deq);
  assign head_entry = mem[head];
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (rdy && enq_ok) mem[tail] <= wr_entry;
  always_ff @(posedge clk)
    if (rst || (rdy && flush)) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      iq_full <= 1'b0;
    end else if (rdy) begin
      if (enq_ok) tail <= tail + IQ_AW'(1);
      if (deq) head <= head + IQ_AW'(1);
      count <= count_nx;
      iq_full <= count_nx >= CAP_M1;
    end
  always_ff @(posedge clk)
    if (!rst && rdy && !flush && enq)
      assert (count != CAP) else $error("inst_queue: enqueue while full, entry dropped");
endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: IQ-backed issue sequencer; fetch in, head_inst/dec_* decode loop, registered RS/LSB/ROB dispatch out
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int IQ_DEPTH = DEF_IQ_DEPTH,
  parameter int IQ_AW = DEF_IQ_AW,
  parameter int ROB_ID_LEN = DEF_ROB_ID_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,
  input  logic                  if_valid,
  input  logic [INS_LEN-1:0]    if_inst,
  input  logic [ADDR_LEN-1:0]   if_pc,
  input  logic                  if_pred_jump,
  output logic                  iq_full,
  output logic [INS_LEN-1:0]    head_inst,
  input  logic [OPENUM_LEN-1:0] dec_op_enum,
  input  logic [REG_LEN-1:0]    dec_rd,
  input  logic [REG_LEN-1:0]    dec_rs1,
  input  logic [REG_LEN-1:0]    dec_rs2,
  input  logic [DATA_LEN-1:0]   dec_imm,
  input  logic                  rob_full,
  input  logic                  rs_full,
  input  logic                  lsb_full,
  input  logic [ROB_ID_LEN-1:0] rob_free_tag,
  output logic                  disp_rob_valid,
  output logic                  disp_rs_valid,
  output logic                  disp_lsb_valid,
  output logic [OPENUM_LEN-1:0] disp_op_enum,
  output logic [REG_LEN-1:0]    disp_rd,
  output logic [REG_LEN-1:0]    disp_rs1,
  output logic [REG_LEN-1:0]    disp_rs2,
  output logic [DATA_LEN-1:0]   disp_imm,
  output logic [ADDR_LEN-1:0]   disp_pc,
  output logic                  disp_pred_jump,
  output logic [ROB_ID_LEN-1:0] disp_rob_tag
);
  iq_entry_t head_entry;
  disp_payload_t pay;
  logic empty, enq, is_ls, is_nop, base, go, drop;
  logic [IQ_AW:0] count;
  assign enq = rdy && if_valid && !rollback;
  inst_queue #(.IQ_DEPTH(IQ_DEPTH), .IQ_AW(IQ_AW)) u_iq (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .flush(rollback),
    .enq(enq),
    .deq(go || drop),
    .wr_entry('{inst: if_inst, pc: if_pc, pred_jump: if_pred_jump}),
    .head_entry(head_entry),
    .empty(empty),
    .iq_full(iq_full),
    .count(count)
  );
  assign head_inst = head_entry.inst;
  always_comb begin
    is_ls = is_ls_op(dec_op_enum);
    is_nop = dec_op_enum == OPENUM_NOP;
    base = rdy && !rollback && !empty;
    go = base && !is_nop && !rob_full && (is_ls ? !lsb_full : !rs_full);
    drop = base && is_nop;
  end
  always_ff @(posedge clk)
    if (rst) begin
      disp_rob_valid <= 1'b0;
      disp_rs_valid <= 1'b0;
      disp_lsb_valid <= 1'b0;
      pay <= '0;
      disp_rob_tag <= '0;
    end else begin
      disp_rob_valid <= go;
      disp_rs_valid <= go && !is_ls;
      disp_lsb_valid <= go && is_ls;
      if (go) begin
        pay <= '{op_enum: dec_op_enum, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, imm: dec_imm,
                 pc: head_entry.pc, pred_jump: head_entry.pred_jump};
        disp_rob_tag <= rob_free_tag;
      end
    end
  assign disp_op_enum = pay.op_enum;
  assign disp_rd = pay.rd;
  assign disp_rs1 = pay.rs1;
  assign disp_rs2 = pay.rs2;
  assign disp_imm = pay.imm;
  assign disp_pc = pay.pc;
  assign disp_pred_jump = pay.pred_jump;
endmodule
